// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared op codes, FSM states and TMS patterns for the JTAG host
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_RUN   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_e;

    // TMS patterns are LSB first: bit 0 goes out on the first tck
    localparam logic [5:0] PRE_TMS_RESET = 6'b011111;
    localparam logic [5:0] PRE_TMS_IR    = 6'b000011;
    localparam logic [5:0] PRE_TMS_DR    = 6'b000001;
    localparam int         PRE_LEN_RESET = 6;
    localparam int         PRE_LEN_IR    = 4;
    localparam int         PRE_LEN_DR    = 3;
    localparam logic [1:0] POST_TMS      = 2'b01;

    function automatic logic [5:0] pre_tms(input op_e op);
        case (op)
            OP_RESET: pre_tms = PRE_TMS_RESET;
            OP_IR:    pre_tms = PRE_TMS_IR;
            OP_DR:    pre_tms = PRE_TMS_DR;
            default:  pre_tms = 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - registered tck divider with strobes for the upcoming rise/fall edges
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic clr,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall,
    output logic tck_pre_fall
);

    localparam int PW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;

    logic [PW-1:0] phase_q, phase_d;
    logic          tck_q, tck_d;

    // Strobes flag that the next sys_clk edge is the rise/fall (or the edge just before the fall)
    assign tck_rise     = en && (phase_q == PW'(CLK_DIV - 1));
    assign tck_fall     = en && (phase_q == PW'(2 * CLK_DIV - 1));
    assign tck_pre_fall = en && (phase_q == PW'(2 * CLK_DIV - 2));
    assign tck          = tck_q;

    always_comb begin
        phase_d = phase_q;
        tck_d   = tck_q;
        if (clr) begin
            phase_d = '0;
            tck_d   = 1'b0;
        end else if (en) begin
            phase_d = tck_fall ? '0 : phase_q + PW'(1);
            tck_d   = (phase_d >= PW'(CLK_DIV));
        end
    end

    always_ff @(posedge sys_clk) begin
        phase_q <= phase_d;
        tck_q   <= tck_d;
    end

endmodule

// File: rtl/jtag_host_driver.sv
// rtl/jtag_host_driver.sv - command-level JTAG host driving tck/tms/tdi/trst and capturing tdo
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               trst,
    input  logic               tdo
);

    localparam int IXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [LEN_W-1:0]   idx_q, idx_d, len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d, tms_q, tms_d, tdi_q, tdi_d;
    logic               trst_q, cmd_ready_q, cmd_ready_d, busy_q;

    logic               accept, last_tck, gen_en, gen_clr;
    logic               tck_rise, tck_fall, tck_pre_fall;
    logic [LEN_W-1:0]   len_clamp, pre_len;
    logic [5:0]         pre_pat_acc, pre_pat_q;

    assign accept    = cmd_valid && cmd_ready_q;
    assign gen_en    = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);
    // DONE is the last high-phase cycle; clearing here doubles as the final falling edge
    assign gen_clr   = reset || (state_q == ST_DONE);
    assign last_tck  = ((op_q == OP_RESET || op_q == OP_RUN) && state_q == ST_PRE
                        && idx_q == pre_len - LEN_W'(1))
                     || (state_q == ST_POST && idx_q == LEN_W'(1));

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .sys_clk      (sys_clk),
        .clr          (gen_clr),
        .en           (gen_en),
        .tck          (tck),
        .tck_rise     (tck_rise),
        .tck_fall     (tck_fall),
        .tck_pre_fall (tck_pre_fall)
    );

    always_comb begin
        len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
        if ((cmd_op == OP_IR || cmd_op == OP_DR) && len_clamp == '0) len_clamp = LEN_W'(1);
        pre_pat_acc = pre_tms(op_e'(cmd_op));
        pre_pat_q   = pre_tms(op_q);
        case (op_q)
            OP_RESET: pre_len = LEN_W'(PRE_LEN_RESET);
            OP_IR:    pre_len = LEN_W'(PRE_LEN_IR);
            OP_DR:    pre_len = LEN_W'(PRE_LEN_DR);
            default:  pre_len = len_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        if (tck_rise && state_q == ST_SHIFT) cap_d[idx_q[IXW-1:0]] = tdo;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d   = op_e'(cmd_op);
                    len_d  = len_clamp;
                    data_d = cmd_data;
                    cap_d  = '0;
                    idx_d  = '0;
                    tdi_d  = 1'b0;
                    if (cmd_op == OP_RUN && len_clamp == '0) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        tms_d       = 1'b0;
                    end else begin
                        state_d = ST_PRE;
                        tms_d   = (cmd_op == OP_RUN) ? 1'b0 : pre_pat_acc[0];
                    end
                end
            end
            default: begin
                if (tck_pre_fall && last_tck) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cap_d;
                end else if (tck_fall) begin
                    case (state_q)
                        ST_PRE: begin
                            if (idx_q == pre_len - LEN_W'(1)) begin
                                state_d = ST_SHIFT;
                                idx_d   = '0;
                            end else idx_d = idx_q + LEN_W'(1);
                        end
                        ST_SHIFT: begin
                            if (idx_q == len_q - LEN_W'(1)) begin
                                state_d = ST_POST;
                                idx_d   = '0;
                            end else idx_d = idx_q + LEN_W'(1);
                        end
                        default: idx_d = idx_q + LEN_W'(1);
                    endcase
                    case (state_d)
                        ST_PRE: begin
                            tms_d = (op_q == OP_RUN) ? 1'b0 : pre_pat_q[idx_d[2:0]];
                            tdi_d = 1'b0;
                        end
                        ST_SHIFT: begin
                            tms_d = (idx_d == len_q - LEN_W'(1));
                            tdi_d = data_q[idx_d[IXW-1:0]];
                        end
                        default: begin
                            tms_d = POST_TMS[idx_d[0]];
                            tdi_d = 1'b0;
                        end
                    endcase
                end
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RESET;
            idx_q       <= '0;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            trst_q      <= 1'b1;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= !cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst      = trst_q;

endmodule
